// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline hazard types and constants
// Purpose : hazard controller FSM state type and architectural constants.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hz_load_use_cmp.sv
// rtl/hz_load_use_cmp.sv - load-use dependency compare
// Purpose : flags when the ID instruction reads the register a load in EXE writes.
// Ports   : id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 - ID source operands
//           exe_rd, exe_wr_en, exe_is_load           - EXE destination info
//           hit                                      - load-use hazard present
module hz_load_use_cmp
  import rv_pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] exe_rd,
  input  logic       exe_wr_en,
  input  logic       exe_is_load,
  output logic       hit
);

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_producer;

  assign w_rs1_match = id_uses_rs1 && (id_rs1 == exe_rd);
  assign w_rs2_match = id_uses_rs2 && (id_rs2 == exe_rd);
  // x0 is never a real producer, so a load targeting it cannot cause a hazard.
  assign w_producer  = exe_is_load && exe_wr_en && (exe_rd != REG_X0);
  assign hit         = w_producer && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline register enable/flush controller
// Purpose : drives en/flush of IF/ID, ID/EXE, EXE/MEM, MEM/WB and PC enable for
//           load-use stalls, EXE redirects, multicycle divides and memory freezes;
//           keeps a saturating stall-cycle counter.
// Ports   : clk, nrst (sync active-low)
//           id_*        - ID operand usage;  exe_*  - EXE instruction info
//           mem_stall   - global freeze
//           pc_en, *_en, *_flush - pipeline register controls
//           div_start   - divider start pulse; div_busy - divide in progress
//           stall_cnt   - saturating count of cycles with pc_en low
module pipeline_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = $clog2(DIV_LAT + 1),
  parameter int PERF_W  = 32
)(
  input  logic              clk,
  input  logic              nrst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        exe_rd,
  input  logic              exe_wr_en,
  input  logic              exe_is_load,
  input  logic              exe_is_div,
  input  logic              exe_redirect,
  input  logic              mem_stall,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_exe_en,
  output logic              id_exe_flush,
  output logic              exe_mem_en,
  output logic              exe_mem_flush,
  output logic              mem_wb_en,
  output logic              div_start,
  output logic              div_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  // Remaining DIV_WAIT cycles, including the current one. The entry cycle is the
  // first stalled cycle, so DIV_WAIT lasts DIV_LAT-2 cycles and DIV_DONE one more,
  // giving DIV_LAT cycles in EXE overall.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_div_cnt;
  logic [CNT_W-1:0]  w_div_cnt_nxt;
  logic [PERF_W-1:0] r_stall_cnt;
  logic              w_load_use;

  hz_load_use_cmp u_cmp (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .exe_rd      (exe_rd),
    .exe_wr_en   (exe_wr_en),
    .exe_is_load (exe_is_load),
    .hit         (w_load_use)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_div_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      if (!pc_en && (r_stall_cnt != {PERF_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_en     = 1'b1;
    id_exe_flush  = 1'b0;
    exe_mem_en    = 1'b1;
    exe_mem_flush = 1'b0;
    mem_wb_en     = 1'b1;
    div_start     = 1'b0;
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;

    if (!nrst) begin
      // Reset: pass-through defaults; registers clear on the edge.
    end else if (mem_stall) begin
      // Freeze everything; state and counter hold, so a pending div_start
      // fires on the first unstalled cycle.
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_exe_en  = 1'b0;
      exe_mem_en = 1'b0;
      mem_wb_en  = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (exe_is_div) begin
            div_start     = 1'b1;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_flush = 1'b1;
            w_div_cnt_nxt = DIV_LOAD;
            w_state_nxt   = (DIV_LAT == 2) ? DIV_DONE : DIV_WAIT;
          end else if (exe_redirect) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
          end else if (w_load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
          end
        end
        DIV_WAIT: begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_exe_en     = 1'b0;
          exe_mem_flush = 1'b1;
          if (r_div_cnt != '0)
            w_div_cnt_nxt = r_div_cnt - CNT_W'(1);
          if (r_div_cnt <= CNT_W'(1))
            w_state_nxt = DIV_DONE;
        end
        DIV_DONE: begin
          // Let the result advance; exe_is_div still shows the finishing op.
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign div_busy  = nrst && (r_state == DIV_WAIT);
  assign stall_cnt = r_stall_cnt;

  // A redirect cannot come from a div, so both together means a decode bug.
  always_ff @(posedge clk) begin
    if (nrst)
      assert (!(exe_redirect && exe_is_div));
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, exe_rd = '0;
  logic        id_uses_rs1 = 0, id_uses_rs2 = 0, exe_wr_en = 0, exe_is_load = 0;
  logic        exe_is_div = 0, exe_redirect = 0, mem_stall = 0;

  logic        pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush;
  logic        exe_mem_en, exe_mem_flush, mem_wb_en, div_start, div_busy;
  logic [31:0] stall_cnt;

  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_exe_en, s_id_exe_flush;
  logic        s_exe_mem_en, s_exe_mem_flush, s_mem_wb_en, s_div_start, s_div_busy;
  logic [2:0]  s_stall_cnt;

  logic [7:0]  outs;
  assign outs = {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush,
                 exe_mem_en, exe_mem_flush, mem_wb_en};

  localparam logic [7:0] O_DEF = 8'b1101_0101;
  localparam logic [7:0] O_LU  = 8'b0001_1101;
  localparam logic [7:0] O_RED = 8'b1111_1101;
  localparam logic [7:0] O_MS  = 8'b0000_0000;
  localparam logic [7:0] O_DIV = 8'b0000_0111;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_LAT(32), .PERF_W(32)) dut (
    .clk(clk), .nrst(nrst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .exe_rd(exe_rd),
    .exe_wr_en(exe_wr_en), .exe_is_load(exe_is_load), .exe_is_div(exe_is_div),
    .exe_redirect(exe_redirect), .mem_stall(mem_stall), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_exe_en(id_exe_en),
    .id_exe_flush(id_exe_flush), .exe_mem_en(exe_mem_en),
    .exe_mem_flush(exe_mem_flush), .mem_wb_en(mem_wb_en),
    .div_start(div_start), .div_busy(div_busy), .stall_cnt(stall_cnt)
  );

  // Narrow counter instance to exercise saturation.
  pipeline_hazard_ctrl #(.DIV_LAT(4), .PERF_W(3)) u_sat (
    .clk(clk), .nrst(nrst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .exe_rd(exe_rd),
    .exe_wr_en(exe_wr_en), .exe_is_load(exe_is_load), .exe_is_div(exe_is_div),
    .exe_redirect(exe_redirect), .mem_stall(mem_stall), .pc_en(s_pc_en),
    .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush), .id_exe_en(s_id_exe_en),
    .id_exe_flush(s_id_exe_flush), .exe_mem_en(s_exe_mem_en),
    .exe_mem_flush(s_exe_mem_flush), .mem_wb_en(s_mem_wb_en),
    .div_start(s_div_start), .div_busy(s_div_busy), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       redir;
    logic       ms;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    exe_rd = v.rd; exe_wr_en = v.wr; exe_is_load = v.ld;
    exe_redirect = v.redir; mem_stall = v.ms;
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; exe_rd = 0;
    exe_wr_en = 0; exe_is_load = 0; exe_is_div = 0; exe_redirect = 0; mem_stall = 0;
  endtask

  // Drive a divide (held in EXE) with an optional mem_stall window; counts
  // cycles with pc_en low up to and excluding the DIV_DONE cycle.
  task automatic run_div(input string nm, input int ms_at, input int ms_len,
                         input int exp_stalls);
    int  n_stall = 0;
    int  n_start = 0;
    bit  done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
      exe_is_div = 1'b1;
      mem_stall  = (k >= ms_at) && (k < ms_at + ms_len);
      @(negedge clk);
      if (mem_stall) begin
        chk({nm, "_freeze_outs"}, outs, O_MS);
        chk({nm, "_freeze_busy"}, div_busy, 1'b1);
      end
      if (pc_en) done = 1;
      else begin
        n_stall++;
        if (div_start) n_start++;
      end
    end
    chk({nm, "_done_seen"}, done, 1'b1);
    chk({nm, "_stall_cycles"}, n_stall, exp_stalls);
    chk({nm, "_start_pulses"}, n_start, 1);
    chk({nm, "_done_outs"}, outs, O_DEF);
    chk({nm, "_done_busy"}, div_busy, 1'b0);
    exp_cnt += exp_stalls;
    chk({nm, "_stall_cnt"}, stall_cnt, exp_cnt);
    @(posedge clk); #1;
    exe_is_div = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_outs"}, outs, O_DEF);
    chk({nm, "_idle_start"}, div_start, 1'b0);
  endtask

  initial begin
    vecs[0] = '{"lu_rs1",      5, 0, 1, 0, 5, 1, 1, 0, 0, O_LU};
    vecs[1] = '{"no_event",    5, 0, 1, 0, 5, 1, 0, 0, 0, O_DEF};
    vecs[2] = '{"lu_x0",       0, 0, 1, 0, 0, 1, 1, 0, 0, O_DEF};
    vecs[3] = '{"rs2_unused",  0, 5, 0, 0, 5, 1, 1, 0, 0, O_DEF};
    vecs[4] = '{"lu_rs2",      0, 5, 0, 1, 5, 1, 1, 0, 0, O_LU};
    vecs[5] = '{"ld_no_wr",    5, 0, 1, 0, 5, 0, 1, 0, 0, O_DEF};
    vecs[6] = '{"alu_prod",    5, 0, 1, 0, 5, 1, 0, 0, 0, O_DEF};
    vecs[7] = '{"redir_lu",    5, 0, 1, 0, 5, 1, 1, 1, 0, O_RED};
    vecs[8] = '{"mstall",      0, 0, 0, 0, 0, 0, 0, 0, 1, O_MS};
    vecs[9] = '{"mstall_lu",   7, 7, 1, 1, 7, 1, 1, 0, 1, O_MS};

    // Reset with a load-use presented: outputs must stay at defaults.
    set_in(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", outs, O_DEF);
    chk("rst_busy", div_busy, 1'b0);
    chk("rst_start", div_start, 1'b0);
    chk("rst_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    clear_in();

    // Table-driven single-cycle behaviour in IDLE.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      set_in(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, "_outs"}, outs, vecs[i].exp);
      chk({vecs[i].name, "_start"}, div_start, 1'b0);
      chk({vecs[i].name, "_cnt"}, stall_cnt, exp_cnt);
      if (vecs[i].exp[7] == 1'b0) exp_cnt++;
    end
    @(posedge clk); #1;
    clear_in();
    @(negedge clk);
    chk("post_table_cnt", stall_cnt, exp_cnt);

    // Plain divide: 31 stalled cycles, then DIV_DONE, then IDLE.
    run_div("div", 1000, 0, 31);
    // Divide with a 5-cycle freeze inside DIV_WAIT: 36 stalled cycles.
    run_div("div_ms", 10, 5, 36);

    // Freeze on the entry cycle defers div_start.
    @(posedge clk); #1;
    exe_is_div = 1'b1; mem_stall = 1'b1;
    @(negedge clk);
    chk("defer_start_held", div_start, 1'b0);
    chk("defer_outs", outs, O_MS);
    @(posedge clk); #1;
    mem_stall = 1'b0;
    @(negedge clk);
    chk("defer_start_fires", div_start, 1'b1);
    chk("defer_div_outs", outs, O_DIV);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_div_busy", div_busy, 1'b1);

    // Reset mid-divide abandons it.
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", outs, O_DEF);
    chk("rst_mid_busy", div_busy, 1'b0);
    @(posedge clk); #1;
    nrst = 1'b1;
    exe_is_div = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("after_rst_busy", div_busy, 1'b0);
    chk("after_rst_outs", outs, O_DEF);
    chk("after_rst_cnt", stall_cnt, 0);
    chk("after_rst_sat_cnt", s_stall_cnt, 3'd0);

    // Ten load-use stalls: wide counter reaches 10, 3-bit one sticks at 7.
    @(posedge clk); #1;
    set_in(vecs[0]);
    repeat (10) @(posedge clk);
    #1;
    clear_in();
    @(negedge clk);
    chk("lu10_cnt", stall_cnt, 10);
    chk("sat_cnt", s_stall_cnt, 3'd7);
    @(posedge clk); #1;
    set_in(vecs[4]);
    @(posedge clk); #1;
    clear_in();
    @(negedge clk);
    chk("sat_hold", s_stall_cnt, 3'd7);
    chk("lu11_cnt", stall_cnt, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
